// File: rtl/time_mode_ctrl.sv
// Mode controller for a digital clock: CLOCK / STOPWATCH / SET_* navigation,
// stopwatch run/clear control, field editing pulses, blink and idle auto-exit.
module time_mode_ctrl #(
    parameter int unsigned AUTO_EXIT_SEC = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       btn_mode,
    input  logic       btn_sel,
    input  logic       btn_inc,
    output logic [1:0] mode,
    output logic       sw_run,
    output logic       sw_clear,
    output logic [1:0] set_field,
    output logic       inc_pulse,
    output logic       blink
);

    localparam int unsigned IDLE_W = 8;
    localparam logic [IDLE_W-1:0] EXIT_CNT = IDLE_W'(AUTO_EXIT_SEC - 1);

    typedef enum logic [2:0] {
        ST_CLOCK,
        ST_STOPWATCH,
        ST_SET_HRS,
        ST_SET_MIN,
        ST_SET_SEC
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IDLE_W-1:0] r_idle;
    logic [IDLE_W-1:0] w_idle_nxt;
    logic [1:0]        r_mode;
    logic [1:0]        w_mode_nxt;
    logic [1:0]        r_set_field;
    logic [1:0]        w_set_field_nxt;
    logic              r_sw_run;
    logic              w_sw_run_nxt;
    logic              r_sw_clear;
    logic              w_sw_clear_nxt;
    logic              r_inc_pulse;
    logic              w_inc_pulse_nxt;
    logic              r_blink;
    logic              w_blink_nxt;

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_CLOCK;
            r_idle      <= '0;
            r_mode      <= 2'd0;
            r_set_field <= 2'd0;
            r_sw_run    <= 1'b0;
            r_sw_clear  <= 1'b0;
            r_inc_pulse <= 1'b0;
            r_blink     <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_idle      <= w_idle_nxt;
            r_mode      <= w_mode_nxt;
            r_set_field <= w_set_field_nxt;
            r_sw_run    <= w_sw_run_nxt;
            r_sw_clear  <= w_sw_clear_nxt;
            r_inc_pulse <= w_inc_pulse_nxt;
            r_blink     <= w_blink_nxt;
        end
    end

    // Next state and next output values; buttons are evaluated in priority order
    always_comb begin
        w_state_nxt     = r_state;
        w_idle_nxt      = '0;
        w_sw_run_nxt    = r_sw_run;
        w_sw_clear_nxt  = 1'b0;
        w_inc_pulse_nxt = 1'b0;
        w_blink_nxt     = 1'b1;
        w_mode_nxt      = 2'd0;
        w_set_field_nxt = 2'd0;

        case (r_state)
            ST_CLOCK: begin
                if (btn_mode) w_state_nxt = ST_STOPWATCH;
            end
            ST_STOPWATCH: begin
                if (btn_mode)                  w_state_nxt    = ST_SET_HRS;
                else if (btn_sel)              w_sw_run_nxt   = ~r_sw_run;
                else if (btn_inc && !r_sw_run) w_sw_clear_nxt = 1'b1;
            end
            ST_SET_HRS, ST_SET_MIN, ST_SET_SEC: begin
                if (btn_mode) begin
                    w_state_nxt = ST_CLOCK;
                end else if (btn_sel) begin
                    case (r_state)
                        ST_SET_HRS: w_state_nxt = ST_SET_MIN;
                        ST_SET_MIN: w_state_nxt = ST_SET_SEC;
                        default:    w_state_nxt = ST_SET_HRS;
                    endcase
                end else if (btn_inc) begin
                    w_inc_pulse_nxt = 1'b1;
                end else if (tick_1hz) begin
                    if (r_idle == EXIT_CNT) begin
                        w_state_nxt = ST_CLOCK;
                    end else begin
                        w_idle_nxt  = r_idle + IDLE_W'(1);
                        w_blink_nxt = ~r_blink;
                    end
                end else begin
                    w_idle_nxt  = r_idle;
                    w_blink_nxt = r_blink;
                end
            end
            default: w_state_nxt = ST_CLOCK;
        endcase

        // mode / set_field follow the state being entered
        case (w_state_nxt)
            ST_STOPWATCH: w_mode_nxt = 2'd1;
            ST_SET_HRS: begin
                w_mode_nxt      = 2'd2;
                w_set_field_nxt = 2'd2;
            end
            ST_SET_MIN: begin
                w_mode_nxt      = 2'd2;
                w_set_field_nxt = 2'd1;
            end
            ST_SET_SEC: w_mode_nxt = 2'd2;
            default:    w_mode_nxt = 2'd0;
        endcase
    end

    assign mode      = r_mode;
    assign sw_run    = r_sw_run;
    assign sw_clear  = r_sw_clear;
    assign set_field = r_set_field;
    assign inc_pulse = r_inc_pulse;
    assign blink     = r_blink;

endmodule

// File: tb/tb_time_mode_ctrl.sv
// Bench for time_mode_ctrl: directed vector table, auto-exit sequences,
// then randomized traffic against an integer-level behavioural model.
module tb_time_mode_ctrl;

    localparam int unsigned AE = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_1hz = 1'b0;
    logic       btn_mode = 1'b0;
    logic       btn_sel = 1'b0;
    logic       btn_inc = 1'b0;
    logic [1:0] mode;
    logic       sw_run;
    logic       sw_clear;
    logic [1:0] set_field;
    logic       inc_pulse;
    logic       blink;

    int checks = 0;
    int errors = 0;

    time_mode_ctrl #(.AUTO_EXIT_SEC(AE)) dut (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz),
        .btn_mode(btn_mode), .btn_sel(btn_sel), .btn_inc(btn_inc),
        .mode(mode), .sw_run(sw_run), .sw_clear(sw_clear),
        .set_field(set_field), .inc_pulse(inc_pulse), .blink(blink)
    );

    always #5 clk = ~clk;

    // Behavioural model: mode as 0/1/2, edited field as 2/1/0, idle as a plain tick count
    int   m_mode  = 0;
    int   m_field = 0;
    int   m_idle  = 0;
    logic m_run   = 1'b0;
    logic m_clear = 1'b0;
    logic m_inc   = 1'b0;
    logic m_blink = 1'b1;

    typedef struct {
        logic       r, t, m, s, i;
        logic [7:0] exp;
    } vec_t;
    vec_t vecs[$];

    function automatic logic [7:0] pk(input int md, input logic run, input logic clr,
                                      input int fld, input logic inc, input logic blk);
        return {2'(md), run, clr, 2'(fld), inc, blk};
    endfunction

    function automatic logic [7:0] model_out();
        return pk(m_mode, m_run, m_clear, (m_mode == 2) ? m_field : 0, m_inc, m_blink);
    endfunction

    task automatic model_step(input logic r, input logic t, input logic m,
                              input logic s, input logic i);
        m_clear = 1'b0;
        m_inc   = 1'b0;
        if (r) begin
            m_mode = 0; m_field = 0; m_run = 1'b0; m_blink = 1'b1; m_idle = 0;
        end else if (m_mode == 0) begin
            if (m) m_mode = 1;
        end else if (m_mode == 1) begin
            if (m) begin
                m_mode = 2; m_field = 2; m_idle = 0; m_blink = 1'b1;
            end else if (s) m_run = ~m_run;
            else if (i && !m_run) m_clear = 1'b1;
        end else begin
            if (m || s || i) begin
                m_idle  = 0;
                m_blink = 1'b1;
                if (m) m_mode = 0;
                else if (s) m_field = (m_field + 2) % 3;
                else m_inc = 1'b1;
            end else if (t) begin
                m_idle = m_idle + 1;
                if (m_idle >= int'(AE)) begin
                    m_mode = 0; m_idle = 0; m_blink = 1'b1;
                end else begin
                    m_blink = ~m_blink;
                end
            end
        end
    endtask

    task automatic drive(input logic r, input logic t, input logic m,
                         input logic s, input logic i);
        @(negedge clk);
        rst = r; tick_1hz = t; btn_mode = m; btn_sel = s; btn_inc = i;
        @(posedge clk);
        #1;
        model_step(r, t, m, s, i);
    endtask

    task automatic check(input string name, input logic [7:0] exp);
        logic [7:0] act;
        act = {mode, sw_run, sw_clear, set_field, inc_pulse, blink};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got {mode,run,clr,field,inc,blink}=%b required %b", name, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic t, input logic m, input logic s,
                       input logic i, input logic [7:0] exp);
        vec_t v;
        v.r = r; v.t = t; v.m = m; v.s = s; v.i = i; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic step_chk(input string name, input logic t, input logic m,
                            input logic s, input logic i, input logic [7:0] exp);
        drive(1'b0, t, m, s, i);
        check(name, exp);
    endtask

    initial begin
        // r t m s i  -> mode run clr field inc blink
        add(1, 0, 0, 0, 0, pk(0, 0, 0, 0, 0, 1));   // reset state
        add(0, 0, 1, 0, 0, pk(1, 0, 0, 0, 0, 1));   // CLOCK -> STOPWATCH
        add(0, 0, 1, 0, 0, pk(2, 0, 0, 2, 0, 1));   // -> SET_HRS
        add(0, 0, 1, 0, 0, pk(0, 0, 0, 0, 0, 1));   // -> CLOCK
        add(0, 0, 1, 0, 0, pk(1, 0, 0, 0, 0, 1));
        add(0, 0, 0, 1, 0, pk(1, 1, 0, 0, 0, 1));   // start
        add(0, 0, 0, 0, 1, pk(1, 1, 0, 0, 0, 1));   // clear ignored while running
        add(0, 0, 0, 1, 0, pk(1, 0, 0, 0, 0, 1));   // stop
        add(0, 0, 0, 0, 1, pk(1, 0, 1, 0, 0, 1));   // clear pulse
        add(0, 0, 0, 0, 0, pk(1, 0, 0, 0, 0, 1));   // pulse is one cycle
        add(0, 0, 0, 1, 1, pk(1, 1, 0, 0, 0, 1));   // sel beats inc
        add(0, 0, 0, 1, 0, pk(1, 0, 0, 0, 0, 1));
        add(0, 0, 1, 0, 0, pk(2, 0, 0, 2, 0, 1));   // SET_HRS
        add(0, 0, 0, 0, 1, pk(2, 0, 0, 2, 1, 1));   // inc hrs
        add(0, 0, 0, 1, 0, pk(2, 0, 0, 1, 0, 1));   // SET_MIN
        add(0, 0, 0, 0, 1, pk(2, 0, 0, 1, 1, 1));   // inc min
        add(0, 0, 0, 1, 0, pk(2, 0, 0, 0, 0, 1));   // SET_SEC
        add(0, 0, 0, 0, 1, pk(2, 0, 0, 0, 1, 1));   // inc sec
        add(0, 0, 0, 1, 0, pk(2, 0, 0, 2, 0, 1));   // wrap to SET_HRS
        add(0, 0, 0, 1, 0, pk(2, 0, 0, 1, 0, 1));   // SET_MIN
        add(0, 0, 1, 0, 1, pk(0, 0, 0, 0, 0, 1));   // mode beats inc
        add(0, 0, 1, 0, 0, pk(1, 0, 0, 0, 0, 1));
        add(0, 0, 0, 1, 0, pk(1, 1, 0, 0, 0, 1));   // running
        add(0, 0, 1, 0, 0, pk(2, 1, 0, 2, 0, 1));   // run kept in SET
        add(0, 0, 0, 1, 0, pk(2, 1, 0, 1, 0, 1));
        add(0, 0, 0, 1, 0, pk(2, 1, 0, 0, 0, 1));   // SET_SEC
        add(1, 1, 0, 0, 1, pk(0, 0, 0, 0, 0, 1));   // reset overrides inputs
        add(0, 0, 0, 0, 0, pk(0, 0, 0, 0, 0, 1));   // no residual pulse

        foreach (vecs[k]) begin
            drive(vecs[k].r, vecs[k].t, vecs[k].m, vecs[k].s, vecs[k].i);
            check($sformatf("vec%0d", k), vecs[k].exp);
        end

        // Auto-exit after three idle ticks
        step_chk("ae_sw",    0, 1, 0, 0, pk(1, 0, 0, 0, 0, 1));
        step_chk("ae_set",   0, 1, 0, 0, pk(2, 0, 0, 2, 0, 1));
        step_chk("ae_t1",    1, 0, 0, 0, pk(2, 0, 0, 2, 0, 0));
        step_chk("ae_idle",  0, 0, 0, 0, pk(2, 0, 0, 2, 0, 0));
        step_chk("ae_t2",    1, 0, 0, 0, pk(2, 0, 0, 2, 0, 1));
        step_chk("ae_t3",    1, 0, 0, 0, pk(0, 0, 0, 0, 0, 1));
        // Button on the third tick restarts the idle count
        step_chk("ae2_sw",   0, 1, 0, 0, pk(1, 0, 0, 0, 0, 1));
        step_chk("ae2_set",  0, 1, 0, 0, pk(2, 0, 0, 2, 0, 1));
        step_chk("ae2_t1",   1, 0, 0, 0, pk(2, 0, 0, 2, 0, 0));
        step_chk("ae2_t2",   1, 0, 0, 0, pk(2, 0, 0, 2, 0, 1));
        step_chk("ae2_t3i",  1, 0, 0, 1, pk(2, 0, 0, 2, 1, 1));
        step_chk("ae2_t4",   1, 0, 0, 0, pk(2, 0, 0, 2, 0, 0));
        step_chk("ae2_sel",  0, 0, 1, 0, pk(2, 0, 0, 1, 0, 1));   // blink forced on
        step_chk("ae2_t5",   1, 0, 0, 0, pk(2, 0, 0, 1, 0, 0));
        step_chk("ae2_t6",   1, 0, 0, 0, pk(2, 0, 0, 1, 0, 1));
        step_chk("ae2_t7",   1, 0, 0, 0, pk(0, 0, 0, 0, 0, 1));
        step_chk("ae2_clk",  1, 0, 0, 0, pk(0, 0, 0, 0, 0, 1));   // ticks ignored in CLOCK

        // Randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            logic r, t, m, s, i;
            r = ($urandom_range(0, 149) == 0);
            t = ($urandom_range(0, 2) == 0);
            m = ($urandom_range(0, 6) == 0);
            s = ($urandom_range(0, 4) == 0);
            i = ($urandom_range(0, 4) == 0);
            drive(r, t, m, s, i);
            check($sformatf("rand%0d", n), model_out());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/time_mode_ctrl.md
TIME_MODE_CTRL -- requirements
Module: time_mode_ctrl

Interface
REQ-001 Parameter AUTO_EXIT_SEC, default 30, SHALL set the number of idle tick_1hz pulses in a SET state before automatic return to CLOCK; legal range 1..255.
REQ-002 clk  input  1  SHALL be the single system clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset, synchronous and active-high.
REQ-004 tick_1hz  input  1  SHALL be a one-clk-wide pulse, once per second, from the clock divider.
REQ-005 btn_mode  input  1  SHALL be a debounced one-clk-wide press pulse that cycles the mode.
REQ-006 btn_sel  input  1  SHALL be a debounced one-clk-wide press pulse: start/stop in stopwatch, next field in set.
REQ-007 btn_inc  input  1  SHALL be a debounced one-clk-wide press pulse: clear in stopwatch, increment in set.
REQ-008 mode  output  2  SHALL encode 0 = CLOCK, 1 = STOPWATCH, 2 = SET; 3 never driven.
REQ-009 sw_run  output  1  SHALL enable stopwatch counting while high.
REQ-010 sw_clear  output  1  SHALL be a one-clk pulse that zeroes the stopwatch counters.
REQ-011 set_field  output  2  SHALL select the edited field: 0 = sec, 1 = min, 2 = hrs; 3 never driven.
REQ-012 inc_pulse  output  1  SHALL be a one-clk pulse that increments the field named by set_field.
REQ-013 blink  output  1  SHALL be the display-enable for the edited field; high means digits shown.

Function
REQ-014 The FSM SHALL have exactly five states: CLOCK, STOPWATCH, SET_HRS, SET_MIN, SET_SEC.
REQ-015 All outputs SHALL be registered; a press sampled at edge N SHALL be reflected on the outputs after edge N.
REQ-016 btn_mode SHALL move CLOCK->STOPWATCH, STOPWATCH->SET_HRS, and any SET_*->CLOCK.
REQ-017 When several buttons are high in the same cycle, priority SHALL be btn_mode > btn_sel > btn_inc; lower-priority presses SHALL be dropped.
REQ-018 mode SHALL be 0 in CLOCK, 1 in STOPWATCH and 2 in every SET_* state.
REQ-019 In STOPWATCH, btn_sel SHALL toggle sw_run.
REQ-020 In STOPWATCH, btn_inc with sw_run = 0 SHALL produce exactly one sw_clear pulse; btn_inc with sw_run = 1 SHALL be ignored.
REQ-021 sw_run SHALL hold its value across mode changes, so the stopwatch keeps running in CLOCK and SET.
REQ-022 In SET_*, btn_sel SHALL advance SET_HRS->SET_MIN->SET_SEC->SET_HRS.
REQ-023 set_field SHALL be 2/1/0 in SET_HRS/SET_MIN/SET_SEC, and 0 outside SET.
REQ-024 In SET_*, btn_inc SHALL produce exactly one inc_pulse with set_field matching the current state.
REQ-025 inc_pulse SHALL never assert outside SET_*.
REQ-026 sw_clear SHALL never assert outside STOPWATCH.
REQ-027 Idle counter, 8 bits:
- counts tick_1hz only in SET_*;
- clears on any button press;
- clears on entry to any SET_* state.
REQ-028 On a tick_1hz while the idle count equals AUTO_EXIT_SEC-1 in SET_*, with no button in that cycle, the FSM SHALL go to CLOCK and the counter SHALL clear.
REQ-029 A button press in the same cycle as tick_1hz SHALL take precedence over counting and auto-exit: counter clears, and the button action executes.
REQ-030 blink SHALL be forced to 1 on entry to SET_* and in every non-SET state.
REQ-031 blink SHALL toggle on each tick_1hz while in SET_*.
REQ-032 blink SHALL be forced to 1 on any btn_sel or btn_inc in SET_*, so the edited digit is visible immediately.

Reset
REQ-033 When rst is high at a clk edge, the block SHALL enter CLOCK with these outputs: mode = 0, sw_run = 0, sw_clear = 0, set_field = 0, inc_pulse = 0, blink = 1, idle counter = 0.
REQ-034 rst SHALL override all button and tick inputs in the same cycle.
REQ-035 rst asserted mid-SET or mid-run SHALL abort with no residual pulse after reset.

Verification
REQ-036 Mode cycle: btn_mode x3 from reset -> mode 1, then 2 with set_field = 2, then 0.
REQ-037 Stopwatch run/clear:
- in STOPWATCH, btn_sel -> sw_run = 1;
- btn_inc -> no sw_clear;
- btn_sel -> sw_run = 0;
- btn_inc -> sw_clear high for exactly 1 cycle.
REQ-038 Set sequencing: in SET_HRS, sequence btn_inc, btn_sel, btn_inc, btn_sel, btn_inc -> three inc_pulses with set_field 2, 1, 0 respectively.
REQ-039 Auto-exit with AUTO_EXIT_SEC = 3:
- enter SET, 3 ticks with no buttons -> mode = 0 after the 3rd tick;
- repeat with btn_inc coincident with the 3rd tick -> mode stays 2, and 3 more idle ticks are required.
REQ-040 Priority/reset:
- btn_mode + btn_inc together in SET_MIN -> CLOCK, no inc_pulse;
- rst with sw_run = 1 in SET_SEC -> all outputs equal reset values next cycle.
